// File: rtl/instr_sequencer.sv
// Program-issue front end for the 4-bit cpu: loadable program memory, PC, issue and result capture.
// Optional SEQ_SINGLE_STEP_EN adds a Step input gating each issue.
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 9,
  parameter int DW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [IW-1:0] LoadInstr,
  input  logic [AW:0]   ProgLen,
  input  logic          Start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          Step,
`endif
  output logic [IW-1:0] Instruction,
  output logic          IssueValid,
  output logic [AW-1:0] PC,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] ResultOut,
  output logic          ResultValid,
  output logic          Busy,
  output logic          Done
);

  localparam logic [IW-1:0] NOP  = IW'(9'b101_0000_00);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc_n;
  logic [AW:0]   len_q, len_n, len_sat;
  logic [IW-1:0] ins_n, cur;
  logic          iv_n;
  logic          go, halt_op, last;

  logic [IW-1:0] mem [DEPTH];

  // Program memory survives reset; loads only outside a run.
  always_ff @(posedge CLK) begin
    if (LoadEn && state != RUN)
      mem[LoadAddr] <= LoadInstr;
  end

`ifdef SEQ_SINGLE_STEP_EN
  assign go = Step;
`else
  assign go = 1'b1;
`endif

  assign cur     = mem[PC];
  assign halt_op = (cur[IW-1 -: 2] == 2'b11);
  assign len_sat = (ProgLen > FULL) ? FULL : ProgLen;
  assign last    = ({1'b0, PC} == len_q - 1'b1);

  always_comb begin
    state_n = state;
    pc_n    = PC;
    len_n   = len_q;
    ins_n   = NOP;
    iv_n    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          pc_n    = '0;
          len_n   = len_sat;
          state_n = (len_sat == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (go) begin
          if (halt_op) begin
            state_n = DONE;
          end else begin
            ins_n = cur;
            iv_n  = 1'b1;
            pc_n  = PC + 1'b1;
            if (last)
              state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      PC          <= '0;
      len_q       <= '0;
      Instruction <= NOP;
      IssueValid  <= 1'b0;
      ResultOut   <= '0;
      ResultValid <= 1'b0;
    end else begin
      state       <= state_n;
      PC          <= pc_n;
      len_q       <= len_n;
      Instruction <= ins_n;
      IssueValid  <= iv_n;
      ResultValid <= IssueValid;
      if (IssueValid)
        ResultOut <= WriteData;
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

endmodule
